// File: rtl/e203_ifu_pcgen.sv
// IFU PC generator: issues fetch requests, hands responses to mini-decode/BPU, applies flush redirects.
// Optional compressed-instruction stepping is enabled by defining E203_PCGEN_RVC_EN.
module e203_ifu_pcgen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_rtvec,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_req_pc,
    input  logic        ifu_rsp_valid,
    output logic        ifu_rsp_ready,
    input  logic [31:0] ifu_rsp_instr,
    input  logic        ir_ready,
    output logic        dec_i_valid,
    output logic [31:0] pc,
    input  logic        prdt_taken,
    input  logic [31:0] prdt_pc_add_op1,
    input  logic [31:0] prdt_pc_add_op2,
    input  logic        bpu_wait,
    input  logic        pipe_flush_req,
    input  logic [31:0] pipe_flush_add_op1,
    input  logic [31:0] pipe_flush_add_op2,
    output logic        pipe_flush_ack
);

    localparam int unsigned PC_W = 32;

`ifdef E203_PCGEN_RVC_EN
    localparam logic [PC_W-1:0] PC_MASK = 32'hFFFF_FFFE;
`else
    localparam logic [PC_W-1:0] PC_MASK = 32'hFFFF_FFFC;
`endif

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e          state_r, state_nxt;
    logic            dsc_r;
    logic [PC_W-1:0] pc_r, pc_nxt_r;

    logic [PC_W-1:0] inc, flush_tgt, prdt_tgt, bpu_nxt;
    logic            rsp_hs;
    logic            ld_pc_r, ld_pc_nxt, set_dsc, clr_dsc;
    logic [PC_W-1:0] pc_r_d, pc_nxt_d;
    logic            instr_unused;

`ifdef E203_PCGEN_RVC_EN
    assign inc = (ifu_rsp_instr[1:0] != 2'b11) ? PC_W'(2) : PC_W'(4);
`else
    assign inc = PC_W'(4);
`endif
    assign instr_unused = ^ifu_rsp_instr;

    // Redirect targets are aligned to the fetch granule
    assign flush_tgt = (pipe_flush_add_op1 + pipe_flush_add_op2) & PC_MASK;
    assign prdt_tgt  = (prdt_pc_add_op1 + prdt_pc_add_op2) & PC_MASK;
    assign bpu_nxt   = prdt_taken ? prdt_tgt : (pc_r + inc);

    assign ifu_rsp_ready = (state_r == ST_WAIT) & (dsc_r | (ir_ready & ~bpu_wait));
    assign rsp_hs        = ifu_rsp_valid & ifu_rsp_ready;
    assign pc            = pc_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RST;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_RST: state_nxt = ST_REQ;
            ST_REQ: begin
                if (ifu_req_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (rsp_hs && (dsc_r || !ifu_req_ready)) state_nxt = ST_REQ;
            end
            default: state_nxt = ST_RST;
        endcase
    end

    // Outputs and datapath load controls
    always_comb begin
        ifu_req_valid  = 1'b0;
        ifu_req_pc     = pc_nxt_r;
        dec_i_valid    = 1'b0;
        pipe_flush_ack = 1'b0;
        ld_pc_r        = 1'b0;
        ld_pc_nxt      = 1'b0;
        set_dsc        = 1'b0;
        clr_dsc        = 1'b0;
        pc_r_d         = '0;
        pc_nxt_d       = '0;
        case (state_r)
            ST_RST: begin
                ld_pc_nxt = 1'b1;
                pc_nxt_d  = pc_rtvec & PC_MASK;
            end
            ST_REQ: begin
                ifu_req_valid  = 1'b1;
                pipe_flush_ack = pipe_flush_req;
                ifu_req_pc     = pipe_flush_req ? flush_tgt : pc_nxt_r;
                if (ifu_req_ready) begin
                    ld_pc_r = 1'b1;
                    pc_r_d  = pipe_flush_req ? flush_tgt : pc_nxt_r;
                end else if (pipe_flush_req) begin
                    ld_pc_nxt = 1'b1;
                    pc_nxt_d  = flush_tgt;
                end
            end
            ST_WAIT: begin
                pipe_flush_ack = pipe_flush_req;
                dec_i_valid    = ifu_rsp_valid & ~dsc_r & ~pipe_flush_req;
                if (dsc_r) begin
                    // Waiting for the response orphaned by an earlier flush
                    clr_dsc = rsp_hs;
                    if (pipe_flush_req) begin
                        ld_pc_nxt = 1'b1;
                        pc_nxt_d  = flush_tgt;
                    end
                end else if (rsp_hs) begin
                    ifu_req_valid = 1'b1;
                    ifu_req_pc    = pipe_flush_req ? flush_tgt : bpu_nxt;
                    if (ifu_req_ready) begin
                        ld_pc_r = 1'b1;
                        pc_r_d  = pipe_flush_req ? flush_tgt : bpu_nxt;
                    end else begin
                        ld_pc_nxt = 1'b1;
                        pc_nxt_d  = pipe_flush_req ? flush_tgt : bpu_nxt;
                    end
                end else if (pipe_flush_req) begin
                    set_dsc   = 1'b1;
                    ld_pc_nxt = 1'b1;
                    pc_nxt_d  = flush_tgt;
                end
            end
            default: ;
        endcase
    end

    // PC and discard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsc_r    <= 1'b0;
            pc_r     <= '0;
            pc_nxt_r <= '0;
        end else begin
            if (set_dsc) begin
                dsc_r <= 1'b1;
            end else if (clr_dsc) begin
                dsc_r <= 1'b0;
            end
            if (ld_pc_r)   pc_r     <= pc_r_d;
            if (ld_pc_nxt) pc_nxt_r <= pc_nxt_d;
        end
    end

endmodule

// File: tb/tb_e203_ifu_pcgen.sv
// Directed bench for e203_ifu_pcgen: reset, sequential fetch, prediction, stall, flush and wrap cases.
module tb_e203_ifu_pcgen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_rtvec;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr;
    logic        ir_ready;
    logic        dec_i_valid;
    logic [31:0] pc;
    logic        prdt_taken;
    logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;
    logic        bpu_wait;
    logic        pipe_flush_req;
    logic [31:0] pipe_flush_add_op1, pipe_flush_add_op2;
    logic        pipe_flush_ack;

    int total = 0;
    int bad   = 0;

    e203_ifu_pcgen dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pc_rtvec           (pc_rtvec),
        .ifu_req_valid      (ifu_req_valid),
        .ifu_req_ready      (ifu_req_ready),
        .ifu_req_pc         (ifu_req_pc),
        .ifu_rsp_valid      (ifu_rsp_valid),
        .ifu_rsp_ready      (ifu_rsp_ready),
        .ifu_rsp_instr      (ifu_rsp_instr),
        .ir_ready           (ir_ready),
        .dec_i_valid        (dec_i_valid),
        .pc                 (pc),
        .prdt_taken         (prdt_taken),
        .prdt_pc_add_op1    (prdt_pc_add_op1),
        .prdt_pc_add_op2    (prdt_pc_add_op2),
        .bpu_wait           (bpu_wait),
        .pipe_flush_req     (pipe_flush_req),
        .pipe_flush_add_op1 (pipe_flush_add_op1),
        .pipe_flush_add_op2 (pipe_flush_add_op2),
        .pipe_flush_ack     (pipe_flush_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then let inputs change away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

`ifdef E203_PCGEN_RVC_EN
    localparam logic [31:0] EXP_C16   = 32'h0000_010A;
    localparam logic [31:0] EXP_WRAP  = 32'hFFFF_FFFE;
    localparam logic [31:0] EXP_WRAP2 = 32'h0000_0002;
`else
    localparam logic [31:0] EXP_C16   = 32'h0000_010C;
    localparam logic [31:0] EXP_WRAP  = 32'hFFFF_FFFC;
    localparam logic [31:0] EXP_WRAP2 = 32'h0000_0000;
`endif

    initial begin
        rst_n = 1'b0; pc_rtvec = 32'h8000_0000; ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b0; ifu_rsp_instr = 32'h0000_0013; ir_ready = 1'b1;
        prdt_taken = 1'b0; prdt_pc_add_op1 = '0; prdt_pc_add_op2 = '0; bpu_wait = 1'b0;
        pipe_flush_req = 1'b1; pipe_flush_add_op1 = '0; pipe_flush_add_op2 = '0;

        // In reset: everything quiet even with a flush request present
        tick(); tick();
        chk("rst_req_valid", 32'(ifu_req_valid), 32'd0);
        chk("rst_rsp_ready", 32'(ifu_rsp_ready), 32'd0);
        chk("rst_flush_ack", 32'(pipe_flush_ack), 32'd0);
        chk("rst_dec_valid", 32'(dec_i_valid), 32'd0);

        // First cycle after release is still quiet
        rst_n = 1'b1; settle();
        chk("rel_req_valid", 32'(ifu_req_valid), 32'd0);
        chk("rel_flush_ack", 32'(pipe_flush_ack), 32'd0);
        pipe_flush_req = 1'b0;
        tick();

        // Second cycle: request the reset vector
        chk("first_req_valid", 32'(ifu_req_valid), 32'd1);
        chk("first_req_pc", ifu_req_pc, 32'h8000_0000);
        tick();

        // Waiting, no response yet
        chk("wait_req_valid", 32'(ifu_req_valid), 32'd0);
        chk("wait_rsp_ready", 32'(ifu_rsp_ready), 32'd1);
        chk("wait_dec_valid", 32'(dec_i_valid), 32'd0);

        // Predicted jump to 0x100
        ifu_rsp_valid = 1'b1; prdt_taken = 1'b1;
        prdt_pc_add_op1 = 32'h0000_00F0; prdt_pc_add_op2 = 32'h0000_0010; settle();
        chk("jmp_dec_valid", 32'(dec_i_valid), 32'd1);
        chk("jmp_pc", pc, 32'h8000_0000);
        chk("jmp_req_valid", 32'(ifu_req_valid), 32'd1);
        chk("jmp_req_pc", ifu_req_pc, 32'h0000_0100);
        tick();

        // Sequential 32-bit instructions
        prdt_taken = 1'b0; settle();
        chk("seq1_pc", pc, 32'h0000_0100);
        chk("seq1_req_pc", ifu_req_pc, 32'h0000_0104);
        tick();
        chk("seq2_pc", pc, 32'h0000_0104);
        chk("seq2_req_pc", ifu_req_pc, 32'h0000_0108);
        tick();

        // Compressed-encoded instruction (steps by 2 only with RVC)
        ifu_rsp_instr = 32'h0000_0001; settle();
        chk("c16_req_pc", ifu_req_pc, EXP_C16);
        tick();

        // Predicted taken with wrap-around addition
        ifu_rsp_instr = 32'h0000_0013; prdt_taken = 1'b1;
        prdt_pc_add_op1 = 32'h0000_0200; prdt_pc_add_op2 = 32'hFFFF_FFF0; settle();
        chk("prdt_pc", pc, EXP_C16);
        chk("prdt_req_pc", ifu_req_pc, 32'h0000_01F0);
        tick();

        // BPU stall for three cycles
        prdt_taken = 1'b0; bpu_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_rsp_ready", 32'(ifu_rsp_ready), 32'd0);
            chk("stall_dec_valid", 32'(dec_i_valid), 32'd1);
            chk("stall_req_valid", 32'(ifu_req_valid), 32'd0);
            chk("stall_pc", pc, 32'h0000_01F0);
            tick();
        end

        // Stall released, fetch side not ready: fall back to REQ
        bpu_wait = 1'b0; ifu_req_ready = 1'b0; settle();
        chk("nrdy_req_valid", 32'(ifu_req_valid), 32'd1);
        chk("nrdy_req_pc", ifu_req_pc, 32'h0000_01F4);
        tick();
        ifu_rsp_valid = 1'b0; settle();
        chk("req_hold_pc", ifu_req_pc, 32'h0000_01F4);
        chk("req_rsp_ready", 32'(ifu_rsp_ready), 32'd0);
        tick();
        ifu_req_ready = 1'b1; settle();
        chk("req_accept_pc", ifu_req_pc, 32'h0000_01F4);
        tick();

        // Flush while waiting with no response
        pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h0000_03F0; pipe_flush_add_op2 = 32'h0000_0010; settle();
        chk("fl_ack", 32'(pipe_flush_ack), 32'd1);
        chk("fl_req_valid", 32'(ifu_req_valid), 32'd0);
        tick();
        pipe_flush_req = 1'b0; settle();
        chk("dsc_rsp_ready", 32'(ifu_rsp_ready), 32'd1);
        chk("dsc_req_valid", 32'(ifu_req_valid), 32'd0);
        tick();
        ifu_rsp_valid = 1'b1; ir_ready = 1'b0; settle();
        chk("dsc_drop_dec", 32'(dec_i_valid), 32'd0);
        chk("dsc_drop_ready", 32'(ifu_rsp_ready), 32'd1);
        chk("dsc_drop_req", 32'(ifu_req_valid), 32'd0);
        tick();
        ifu_rsp_valid = 1'b0; ir_ready = 1'b1; settle();
        chk("fl_tgt_valid", 32'(ifu_req_valid), 32'd1);
        chk("fl_tgt_pc", ifu_req_pc, 32'h0000_0400);
        tick();

        // Flush with response handshake, fetch not ready; prediction ignored
        ifu_rsp_valid = 1'b1; pipe_flush_req = 1'b1; ifu_req_ready = 1'b0;
        pipe_flush_add_op1 = 32'h0000_0500; pipe_flush_add_op2 = 32'h0000_0004;
        prdt_taken = 1'b1; prdt_pc_add_op1 = 32'h0000_0900; prdt_pc_add_op2 = '0; settle();
        chk("flhs_dec", 32'(dec_i_valid), 32'd0);
        chk("flhs_ack", 32'(pipe_flush_ack), 32'd1);
        chk("flhs_req_valid", 32'(ifu_req_valid), 32'd1);
        chk("flhs_req_pc", ifu_req_pc, 32'h0000_0504);
        tick();
        ifu_rsp_valid = 1'b0; pipe_flush_req = 1'b0; prdt_taken = 1'b0; settle();
        chk("flhs_hold_pc", ifu_req_pc, 32'h0000_0504);
        tick();
        ifu_req_ready = 1'b1; settle();
        chk("flhs_accept_pc", ifu_req_pc, 32'h0000_0504);
        tick();

        // Misaligned flush target near top of address space, then wrap
        ifu_rsp_valid = 1'b1; pipe_flush_req = 1'b1;
        pipe_flush_add_op1 = 32'hFFFF_FFF0; pipe_flush_add_op2 = 32'h0000_000F; settle();
        chk("align_req_pc", ifu_req_pc, EXP_WRAP);
        chk("align_dec", 32'(dec_i_valid), 32'd0);
        tick();
        pipe_flush_req = 1'b0; settle();
        chk("wrap_pc", pc, EXP_WRAP);
        chk("wrap_req_pc", ifu_req_pc, EXP_WRAP2);
        chk("wrap_req_bit0", 32'(ifu_req_pc[0]), 32'd0);
        tick();

        // Flush in REQ state replaces the pending address
        ifu_req_ready = 1'b0; settle();
        tick();
        ifu_rsp_valid = 1'b0; pipe_flush_req = 1'b1;
        pipe_flush_add_op1 = 32'h0000_0700; pipe_flush_add_op2 = '0; settle();
        chk("reqfl_ack", 32'(pipe_flush_ack), 32'd1);
        chk("reqfl_pc", ifu_req_pc, 32'h0000_0700);
        tick();
        pipe_flush_req = 1'b0; settle();
        chk("reqfl_hold_pc", ifu_req_pc, 32'h0000_0700);

        // Asynchronous reset mid-request
        #2 rst_n = 1'b0; #1;
        chk("arst_req_valid", 32'(ifu_req_valid), 32'd0);
        chk("arst_pc", pc, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
